// File: rtl/score_keeper.sv
// Pinball score keeper: collapses per-pixel collisions into per-frame events and
// tracks a saturating BCD score, remaining lives and the game-over state.
module score_keeper #(
    parameter int INIT_LIVES = 3,
    parameter int HIT_POINTS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       collisionSmileyFlipper,
    input  logic       collisionSmileyBottom,
    input  logic       restart,
    output logic [3:0] scoreOnes,
    output logic [3:0] scoreTens,
    output logic [3:0] scoreHundreds,
    output logic [1:0] lives,
    output logic       gameOver,
    output logic       hitPulse
);

    localparam logic [0:0] PLAY      = 1'b0;
    localparam logic [0:0] GAME_OVER = 1'b1;

    localparam logic [4:0] HIT_INC    = 5'(HIT_POINTS);
    localparam logic [1:0] LIVES_INIT = 2'(INIT_LIVES);

    logic [0:0] state_q, state_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] hund_q, hund_d;
    logic [1:0] lives_q, lives_d;
    logic       hitPulse_q, hitPulse_d;
    logic       flipHit_q, flipHit_d;
    logic       bottomHit_q, bottomHit_d;
    logic       prevFlip_q, prevFlip_d;
    logic       prevBottom_q, prevBottom_d;

    logic       scoredHit;
    logic       lifeLost;
    logic [4:0] onesSum;
    logic [4:0] tensSum;
    logic [4:0] hundSum;
    logic [3:0] onesAdd;
    logic [3:0] tensAdd;
    logic [3:0] hundAdd;
    logic       carryOnes;
    logic       carryTens;

    // Rising edge of the frame flag: a contact spanning several frames counts once.
    assign scoredHit = startOfFrame && flipHit_q && !prevFlip_q;
    assign lifeLost  = startOfFrame && bottomHit_q && !prevBottom_q;

    always_comb begin
        onesSum   = {1'b0, ones_q} + HIT_INC;
        carryOnes = (onesSum > 5'd9);
        onesAdd   = carryOnes ? 4'(onesSum - 5'd10) : onesSum[3:0];

        tensSum   = {1'b0, tens_q} + {4'd0, carryOnes};
        carryTens = (tensSum > 5'd9);
        tensAdd   = carryTens ? 4'd0 : tensSum[3:0];

        hundSum   = {1'b0, hund_q} + {4'd0, carryTens};
        hundAdd   = hundSum[3:0];

        // A carry out of the hundreds digit clamps the whole score at 999.
        if (hundSum > 5'd9) begin
            onesAdd = 4'd9;
            tensAdd = 4'd9;
            hundAdd = 4'd9;
        end
    end

    always_comb begin
        state_d      = state_q;
        ones_d       = ones_q;
        tens_d       = tens_q;
        hund_d       = hund_q;
        lives_d      = lives_q;
        hitPulse_d   = 1'b0;
        flipHit_d    = flipHit_q | collisionSmileyFlipper;
        bottomHit_d  = bottomHit_q | collisionSmileyBottom;
        prevFlip_d   = prevFlip_q;
        prevBottom_d = prevBottom_q;

        // A collision on the frame-start cycle already belongs to the new frame.
        if (startOfFrame) begin
            prevFlip_d   = flipHit_q;
            prevBottom_d = bottomHit_q;
            flipHit_d    = collisionSmileyFlipper;
            bottomHit_d  = collisionSmileyBottom;
        end

        if (state_q == PLAY) begin
            if (scoredHit) begin
                ones_d     = onesAdd;
                tens_d     = tensAdd;
                hund_d     = hundAdd;
                hitPulse_d = 1'b1;
            end
            if (lifeLost && (lives_q != 2'd0)) begin
                lives_d = lives_q - 2'd1;
                if (lives_q == 2'd1) begin
                    state_d = GAME_OVER;
                end
            end
        end

        if (restart) begin
            state_d      = PLAY;
            ones_d       = 4'd0;
            tens_d       = 4'd0;
            hund_d       = 4'd0;
            lives_d      = LIVES_INIT;
            hitPulse_d   = 1'b0;
            flipHit_d    = 1'b0;
            bottomHit_d  = 1'b0;
            prevFlip_d   = 1'b0;
            prevBottom_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PLAY;
            ones_q       <= 4'd0;
            tens_q       <= 4'd0;
            hund_q       <= 4'd0;
            lives_q      <= LIVES_INIT;
            hitPulse_q   <= 1'b0;
            flipHit_q    <= 1'b0;
            bottomHit_q  <= 1'b0;
            prevFlip_q   <= 1'b0;
            prevBottom_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ones_q       <= ones_d;
            tens_q       <= tens_d;
            hund_q       <= hund_d;
            lives_q      <= lives_d;
            hitPulse_q   <= hitPulse_d;
            flipHit_q    <= flipHit_d;
            bottomHit_q  <= bottomHit_d;
            prevFlip_q   <= prevFlip_d;
            prevBottom_q <= prevBottom_d;
        end
    end

    assign scoreOnes     = ones_q;
    assign scoreTens     = tens_q;
    assign scoreHundreds = hund_q;
    assign lives         = lives_q;
    assign gameOver      = (state_q == GAME_OVER);
    assign hitPulse      = hitPulse_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a default instance for game flow, plus two
// instances (HIT_POINTS 9 and 7) sharing one stimulus for BCD carry and clamping.
module tb_score_keeper;

    logic clk;
    logic reset;
    logic startOfFrame;
    logic collisionSmileyFlipper;
    logic collisionSmileyBottom;
    logic restart;
    logic [3:0] scoreOnes, scoreTens, scoreHundreds;
    logic [1:0] lives;
    logic gameOver;
    logic hitPulse;

    logic satReset;
    logic satSof;
    logic satFlip;
    logic satIdle;
    logic [3:0] s9Ones, s9Tens, s9Hund;
    logic [1:0] s9Lives;
    logic s9GameOver, s9HitPulse;
    logic [3:0] s7Ones, s7Tens, s7Hund;
    logic [1:0] s7Lives;
    logic s7GameOver, s7HitPulse;

    int testCount = 0;
    int failCount = 0;

    score_keeper dut (
        .clk                   (clk),
        .reset                 (reset),
        .startOfFrame          (startOfFrame),
        .collisionSmileyFlipper(collisionSmileyFlipper),
        .collisionSmileyBottom (collisionSmileyBottom),
        .restart               (restart),
        .scoreOnes             (scoreOnes),
        .scoreTens             (scoreTens),
        .scoreHundreds         (scoreHundreds),
        .lives                 (lives),
        .gameOver              (gameOver),
        .hitPulse              (hitPulse)
    );

    score_keeper #(.INIT_LIVES(3), .HIT_POINTS(9)) dut9 (
        .clk                   (clk),
        .reset                 (satReset),
        .startOfFrame          (satSof),
        .collisionSmileyFlipper(satFlip),
        .collisionSmileyBottom (satIdle),
        .restart               (satIdle),
        .scoreOnes             (s9Ones),
        .scoreTens             (s9Tens),
        .scoreHundreds         (s9Hund),
        .lives                 (s9Lives),
        .gameOver              (s9GameOver),
        .hitPulse              (s9HitPulse)
    );

    score_keeper #(.INIT_LIVES(3), .HIT_POINTS(7)) dut7 (
        .clk                   (clk),
        .reset                 (satReset),
        .startOfFrame          (satSof),
        .collisionSmileyFlipper(satFlip),
        .collisionSmileyBottom (satIdle),
        .restart               (satIdle),
        .scoreOnes             (s7Ones),
        .scoreTens             (s7Tens),
        .scoreHundreds         (s7Hund),
        .lives                 (s7Lives),
        .gameOver              (s7GameOver),
        .hitPulse              (s7HitPulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [11:0] observed,
                               input logic [11:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [11:0] toBcd(input int value);
        int v;
        v = (value > 999) ? 999 : value;
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Five cycles of contact, then a frame-start pulse; returns one cycle after it.
    task automatic applyStimulus(input logic flipOn, input logic bottomOn, input logic flipAtSof);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            collisionSmileyFlipper = flipOn;
            collisionSmileyBottom  = bottomOn;
        end
        @(negedge clk);
        collisionSmileyFlipper = flipAtSof;
        collisionSmileyBottom  = 1'b0;
        startOfFrame           = 1'b1;
        @(negedge clk);
        startOfFrame           = 1'b0;
        collisionSmileyFlipper = 1'b0;
    endtask

    // One empty frame to clear the previous-frame flag, then one scoring frame.
    task automatic applySatStimulus();
        @(negedge clk);
        satSof = 1'b1;
        @(negedge clk);
        satSof  = 1'b0;
        satFlip = 1'b1;
        @(negedge clk);
        satFlip = 1'b0;
        satSof  = 1'b1;
        @(negedge clk);
        satSof = 1'b0;
    endtask

    function automatic logic [11:0] mainScore();
        return {scoreHundreds, scoreTens, scoreOnes};
    endfunction

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        startOfFrame = 1'b0;
        collisionSmileyFlipper = 1'b0;
        collisionSmileyBottom = 1'b0;
        restart = 1'b0;
        satReset = 1'b1;
        satSof = 1'b0;
        satFlip = 1'b0;
        satIdle = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset score", mainScore(), 12'h000);
        checkOutput("reset lives", 12'(lives), 12'd3);
        checkOutput("reset gameOver", 12'(gameOver), 12'd0);
        checkOutput("reset hitPulse", 12'(hitPulse), 12'd0);
        reset = 1'b0;
        satReset = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("first hit score", mainScore(), 12'h001);
        checkOutput("first hit pulse", 12'(hitPulse), 12'd1);
        @(negedge clk);
        checkOutput("pulse one cycle", 12'(hitPulse), 12'd0);

        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("empty frame score", mainScore(), 12'h001);

        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("held N score", mainScore(), 12'h002);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("held N+1 score", mainScore(), 12'h002);
        checkOutput("held N+1 pulse", 12'(hitPulse), 12'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("held N+2 score", mainScore(), 12'h002);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("absent N+3 score", mainScore(), 12'h002);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("again N+4 score", mainScore(), 12'h003);
        checkOutput("again N+4 pulse", 12'(hitPulse), 12'd1);

        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("sof-cycle contact no early hit", mainScore(), 12'h003);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("sof-cycle contact kept", mainScore(), 12'h004);
        checkOutput("sof-cycle contact pulse", 12'(hitPulse), 12'd1);

        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        collisionSmileyFlipper = 1'b1;
        repeat (3) @(negedge clk);
        collisionSmileyFlipper = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("mid-frame reset score", mainScore(), 12'h000);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("mid-frame reset no hit", mainScore(), 12'h000);
        checkOutput("mid-frame reset no pulse", 12'(hitPulse), 12'd0);

        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("first loss lives", 12'(lives), 12'd2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("held bottom lives", 12'(lives), 12'd2);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("second loss lives", 12'(lives), 12'd1);
        checkOutput("still playing", 12'(gameOver), 12'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("last life score", mainScore(), 12'h001);
        checkOutput("last life lives", 12'(lives), 12'd0);
        checkOutput("last life gameOver", 12'(gameOver), 12'd1);
        checkOutput("last life pulse", 12'(hitPulse), 12'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("game over score held", mainScore(), 12'h001);
        checkOutput("game over no pulse", 12'(hitPulse), 12'd0);
        checkOutput("game over stays", 12'(gameOver), 12'd1);

        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        collisionSmileyFlipper = 1'b1;
        repeat (3) @(negedge clk);
        collisionSmileyFlipper = 1'b0;
        startOfFrame = 1'b1;
        restart = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        restart = 1'b0;
        checkOutput("restart score", mainScore(), 12'h000);
        checkOutput("restart lives", 12'(lives), 12'd3);
        checkOutput("restart gameOver", 12'(gameOver), 12'd0);
        checkOutput("restart pulse", 12'(hitPulse), 12'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("restart cleared flags", mainScore(), 12'h000);

        // 095 and 998 are not multiples of 9, so carries and clamping are
        // exercised at reachable scores: 099->108, 990->999, 999->999, 994+7->999.
        for (int n = 1; n <= 144; n++) begin
            applySatStimulus();
            if (n == 11 || n == 12 || n == 110 || n == 111 || n == 112 || n == 144) begin
                checkOutput($sformatf("hp9 score after %0d hits", n),
                            {s9Hund, s9Tens, s9Ones}, toBcd(n * 9));
                checkOutput($sformatf("hp9 pulse after %0d hits", n), 12'(s9HitPulse), 12'd1);
            end
            if (n == 12 || n == 142 || n == 143 || n == 144) begin
                checkOutput($sformatf("hp7 score after %0d hits", n),
                            {s7Hund, s7Tens, s7Ones}, toBcd(n * 7));
                checkOutput($sformatf("hp7 pulse after %0d hits", n), 12'(s7HitPulse), 12'd1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
